gf_inv_sched: RTL

Round-robin scheduler that shares one GF(2^m) inverse-array core between two requesters. Each requester submits a job of degree, polynomial and four 5-bit field elements in one parallel transfer. The block serialises the job into the core's 4-beat input protocol and collects the core's 4-beat result. It then returns the four inverses to the originating requester, tagged, with a watchdog for a hung core.

---
 rtl/gf_inv_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gf_inv_sched.sv
// Round-robin front end sharing one GF(2^m) inverse-array core between two requesters.
// Serialises a job into 4 core input beats, gathers 4 result beats, and returns them tagged, with a watchdog.
module gf_inv_sched #(
  parameter int unsigned TIMEOUT = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [2:0]  req0_deg,
  input  logic [5:0]  req0_poly,
  input  logic [19:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_deg,
  input  logic [5:0]  req1_poly,
  input  logic [19:0] req1_data,
  output logic        req1_ready,
  output logic        core_in_valid,
  output logic [2:0]  core_deg,
  output logic [5:0]  core_poly,
  output logic [4:0]  core_in_data,
  input  logic        core_out_valid,
  input  logic [4:0]  core_out_data,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [19:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [2:0] {
    ST_BOOT, ST_IDLE, ST_ISSUE, ST_WAIT, ST_COLLECT, ST_RESP
  } state_t;

  localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

  state_t      state, state_nx;
  logic        last_q, id_q, err_q;
  logic [2:0]  deg_q;
  logic [5:0]  poly_q;
  logic [19:0] data_q, res_q;
  logic [1:0]  beat_q;
  logic [8:0]  wait_q;
  logic        grant, accept;
  logic [4:0]  beat_elem;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = (state == ST_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    beat_elem = '0;
    case (beat_q)
      2'd0: beat_elem = data_q[4:0];
      2'd1: beat_elem = data_q[9:5];
      2'd2: beat_elem = data_q[14:10];
      2'd3: beat_elem = data_q[19:15];
      default: beat_elem = '0;
    endcase
  end

  assign core_in_valid = (state == ST_ISSUE);
  assign core_deg      = (state == ST_ISSUE) ? deg_q  : '0;
  assign core_poly     = (state == ST_ISSUE) ? poly_q : '0;
  assign core_in_data  = (state == ST_ISSUE) ? beat_elem : '0;

  assign resp_valid = (state == ST_RESP);
  assign resp_id    = (state == ST_RESP) ? id_q  : 1'b0;
  assign resp_data  = (state == ST_RESP) ? res_q : '0;
  assign resp_err   = (state == ST_RESP) ? err_q : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_BOOT:    state_nx = ST_IDLE;
      ST_IDLE:    if (accept) state_nx = ST_ISSUE;
      ST_ISSUE:   if (beat_q == 2'd3) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (core_out_valid)              state_nx = ST_COLLECT;
        else if (wait_q == TIMEOUT_CNT)  state_nx = ST_RESP;
      end
      ST_COLLECT: if (!core_out_valid || beat_q == 2'd3) state_nx = ST_RESP;
      ST_RESP:    state_nx = ST_IDLE;
      default:    state_nx = ST_BOOT;
    endcase
  end

  // The first result beat is captured in WAIT itself so the collect beats
  // occupy exactly four consecutive cycles starting with the first strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      id_q   <= 1'b0;
      err_q  <= 1'b0;
      deg_q  <= '0;
      poly_q <= '0;
      data_q <= '0;
      res_q  <= '0;
      beat_q <= '0;
      wait_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          id_q   <= grant;
          deg_q  <= grant ? req1_deg  : req0_deg;
          poly_q <= grant ? req1_poly : req0_poly;
          data_q <= grant ? req1_data : req0_data;
          beat_q <= '0;
          wait_q <= '0;
          res_q  <= '0;
          err_q  <= 1'b0;
        end
        ST_ISSUE: beat_q <= beat_q + 2'd1;
        ST_WAIT: begin
          if (core_out_valid) begin
            res_q[4:0] <= core_out_data;
            beat_q     <= 2'd1;
          end else if (wait_q == TIMEOUT_CNT) begin
            err_q <= 1'b1;
            res_q <= '0;
          end else begin
            wait_q <= wait_q + 9'd1;
          end
        end
        ST_COLLECT: begin
          if (core_out_valid) begin
            case (beat_q)
              2'd0: res_q[4:0]   <= core_out_data;
              2'd1: res_q[9:5]   <= core_out_data;
              2'd2: res_q[14:10] <= core_out_data;
              2'd3: res_q[19:15] <= core_out_data;
              default: ;
            endcase
            beat_q <= beat_q + 2'd1;
          end else begin
            err_q <= 1'b1;
            res_q <= '0;
          end
        end
        ST_RESP: last_q <= id_q;
        default: ;
      endcase
    end
  end

endmodule
